dclk_fifo_lut: RTL and testbench

DCLK_FIFO_LUT -- requirements
Module: dclk_fifo_lut

---
 rtl/dclk_fifo_lut.sv | 73 +++++++
 tb/tb_dclk_fifo_lut.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dclk_fifo_lut.sv
// Single-clock FIFO built on a distributed (LUT) register array.
// Read data is registered; pointers carry one extra wrap bit to separate full from empty.
module dclk_fifo_lut #(
   parameter int LOG2_FIFO_DEPTH = 3,
   parameter int FIFO_WIDTH      = 8
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       wen,
   input  logic [FIFO_WIDTH-1:0]      wdata,
   output logic                       wfull,
   output logic [LOG2_FIFO_DEPTH:0]   wlevel,
   input  logic                       ren,
   output logic [FIFO_WIDTH-1:0]      rdata,
   output logic                       rempty,
   output logic [LOG2_FIFO_DEPTH:0]   rlevel
);

   localparam int AW    = LOG2_FIFO_DEPTH;
   localparam int DEPTH = 2 ** AW;

   logic [FIFO_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_rptr;
   logic [FIFO_WIDTH-1:0] r_rdata;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_wrEn;
   logic                  w_rdEn;
   logic [AW:0]           w_level;

   // Equal pointers mean empty; equal addresses with differing wrap bits mean full.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_level = r_wptr - r_rptr;

   assign w_wrEn  = wen && !w_full;
   assign w_rdEn  = ren && !w_empty;

   // Storage array is intentionally left out of reset so it maps onto LUT RAM.
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[r_wptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wptr <= '0;
      end else if (w_wrEn) begin
         r_wptr <= r_wptr + 1'b1;
      end
   end

   // rdata only moves on an accepted read, so it holds across idle and underflow cycles.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rptr  <= '0;
         r_rdata <= '0;
      end else if (w_rdEn) begin
         r_rptr  <= r_rptr + 1'b1;
         r_rdata <= r_mem[r_rptr[AW-1:0]];
      end
   end

   assign wfull  = w_full;
   assign rempty = w_empty;
   assign wlevel = w_level;
   assign rlevel = w_level;
   assign rdata  = r_rdata;

endmodule

// File: tb/tb_dclk_fifo_lut.sv
// Directed bench for dclk_fifo_lut with a queue scoreboard of written words.
// The scoreboard alone decides which reads and writes should be accepted.
module tb_dclk_fifo_lut;

   localparam int AW    = 3;
   localparam int W     = 8;
   localparam int DEPTH = 2 ** AW;

   logic          clk;
   logic          arst_n;
   logic          wen;
   logic [W-1:0]  wdata;
   logic          wfull;
   logic [AW:0]   wlevel;
   logic          ren;
   logic [W-1:0]  rdata;
   logic          rempty;
   logic [AW:0]   rlevel;

   logic [W-1:0]  sbQueue [$];
   logic [W-1:0]  expRdata;
   int            assertCount;
   int            failCount;

   dclk_fifo_lut #(
      .LOG2_FIFO_DEPTH (AW),
      .FIFO_WIDTH      (W)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .wen    (wen),
      .wdata  (wdata),
      .wfull  (wfull),
      .wlevel (wlevel),
      .ren    (ren),
      .rdata  (rdata),
      .rempty (rempty),
      .rlevel (rlevel)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a stuck run still reports and terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Compare every output against the scoreboard state.
   task automatic checkOutput(input string tag);
      checkEq({tag, ":rdata"},  32'(rdata),  32'(expRdata));
      checkEq({tag, ":wlevel"}, 32'(wlevel), 32'(sbQueue.size()));
      checkEq({tag, ":rlevel"}, 32'(rlevel), 32'(sbQueue.size()));
      checkEq({tag, ":rempty"}, 32'(rempty), 32'(sbQueue.size() == 0));
      checkEq({tag, ":wfull"},  32'(wfull),  32'(sbQueue.size() == DEPTH));
   endtask

   // Drive one cycle of requests, update the scoreboard at the edge, check 1 ns later.
   task automatic applyStimulus(input logic w, input logic [W-1:0] d, input logic r, input string tag);
      logic doWr;
      logic doRd;
      wen   = w;
      wdata = d;
      ren   = r;
      doWr  = w && (sbQueue.size() < DEPTH);
      doRd  = r && (sbQueue.size() > 0);
      @(posedge clk);
      if (doRd) expRdata = sbQueue.pop_front();
      if (doWr) sbQueue.push_back(d);
      #1;
      wen = 1'b0;
      ren = 1'b0;
      checkOutput(tag);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      expRdata    = '0;
      arst_n      = 1'b0;
      wen         = 1'b0;
      ren         = 1'b0;
      wdata       = '0;

      #12;
      checkOutput("reset");
      #10 arst_n = 1'b1;

      // Fill 1..8, then an overflow write of 10.
      for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, W'(i), 1'b0, "fill");
      applyStimulus(1'b1, 8'd10, 1'b0, "overflow");

      // Drain 1..8, then one underflow read that must leave rdata at 8.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, "drain");
      applyStimulus(1'b0, '0, 1'b1, "underflow");
      checkEq("underflowHold", 32'(rdata), 32'd8);

      // Streaming across the pointer wrap with ren following rempty.
      for (int i = 21; i <= 28; i++) applyStimulus(1'b1, W'(i), !rempty, "stream");
      for (int i = 0; i < 4 * DEPTH && !rempty; i++) applyStimulus(1'b0, '0, 1'b1, "streamDrain");
      checkEq("streamLast", 32'(rdata), 32'd28);
      checkEq("streamEmpty", 32'(sbQueue.size()), 32'(dut.rlevel));

      // Simultaneous read/write at level 4, then at full, then at empty.
      for (int i = 31; i <= 34; i++) applyStimulus(1'b1, W'(i), 1'b0, "simFill");
      for (int i = 35; i <= 37; i++) applyStimulus(1'b1, W'(i), 1'b1, "simLevel4");
      while (sbQueue.size() < DEPTH) applyStimulus(1'b1, W'(40 + sbQueue.size()), 1'b0, "simTop");
      applyStimulus(1'b1, 8'd99, 1'b1, "simFull");
      checkEq("simFullLevel", 32'(wlevel), 32'd7);
      for (int i = 0; i < 4 * DEPTH && sbQueue.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, "simDrain");
      applyStimulus(1'b1, 8'h5A, 1'b1, "simEmpty");
      applyStimulus(1'b0, '0, 1'b1, "simEmptyRead");

      // Asynchronous reset at level 5, asserted between clock edges.
      for (int i = 61; i <= 65; i++) applyStimulus(1'b1, W'(i), 1'b0, "preReset");
      #2 arst_n = 1'b0;
      #1;
      sbQueue.delete();
      expRdata = '0;
      checkOutput("asyncReset");
      #3 arst_n = 1'b1;
      applyStimulus(1'b0, '0, 1'b1, "postResetRead");
      applyStimulus(1'b1, 8'h77, 1'b0, "postResetWrite");
      applyStimulus(1'b0, '0, 1'b1, "postResetReadBack");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
